logic_reduce_pipe: RTL and testbench



---
 rtl/logic_reduce_pipe_if.sv | 29 ++
 rtl/logic_reduce_pipe.sv | 74 +++++++
 tb/tb_logic_reduce_pipe.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/logic_reduce_pipe_if.sv
// logic_reduce_pipe_if: valid/ready bundle between a producer, logic_reduce_pipe and a consumer
// in side : io_in_valid, io_in_ready, io_in_op, io_in_a (NUM_IN operands of WIDTH bits), io_in_last
// out side: io_out_valid, io_out_ready, io_out_y, io_out_zero, io_out_beats (LOGIC_REDUCE_BEATS_EN only)
interface logic_reduce_pipe_if #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 2
);
    logic                    io_in_valid;
    logic                    io_in_ready;
    logic [1:0]              io_in_op;
    logic [NUM_IN*WIDTH-1:0] io_in_a;
    logic                    io_in_last;
    logic                    io_out_valid;
    logic                    io_out_ready;
    logic [WIDTH-1:0]        io_out_y;
    logic                    io_out_zero;
`ifdef LOGIC_REDUCE_BEATS_EN
    logic [7:0]              io_out_beats;
    modport slave  (input  io_in_valid, io_in_op, io_in_a, io_in_last, io_out_ready,
                    output io_in_ready, io_out_valid, io_out_y, io_out_zero, io_out_beats);
    modport master (output io_in_valid, io_in_op, io_in_a, io_in_last, io_out_ready,
                    input  io_in_ready, io_out_valid, io_out_y, io_out_zero, io_out_beats);
`else
    modport slave  (input  io_in_valid, io_in_op, io_in_a, io_in_last, io_out_ready,
                    output io_in_ready, io_out_valid, io_out_y, io_out_zero);
    modport master (output io_in_valid, io_in_op, io_in_a, io_in_last, io_out_ready,
                    input  io_in_ready, io_out_valid, io_out_y, io_out_zero);
`endif
endinterface

// File: rtl/logic_reduce_pipe.sv
// logic_reduce_pipe: registered AND/OR/XOR/NAND fold of NUM_IN operands, accumulated over a multi-beat packet
// ports: clock, reset (async, active-high), io (logic_reduce_pipe_if.slave)
// LOGIC_REDUCE_BEATS_EN adds io_out_beats, the saturating beat count of the reported packet
module logic_reduce_pipe #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 2
) (
    input logic clock,
    input logic reset,
    logic_reduce_pipe_if.slave io
);
    typedef enum logic {IDLE, ACCUM} state_t;
    state_t           state, state_n;
    logic [WIDTH-1:0] acc, b, acc_n, y_n, y_q;
    logic [1:0]       op_reg, op_eff;
    logic             valid_q, fire, fire_last;

    function automatic logic [WIDTH-1:0] base(input logic [1:0] op, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        return op == 2'b01 ? x | y : op == 2'b10 ? x ^ y : x & y;
    endfunction

    assign io.io_in_ready  = !valid_q || io.io_out_ready;
    assign fire            = io.io_in_valid && io.io_in_ready;
    assign fire_last       = fire && io.io_in_last;
    // the op is latched on the first beat; later beats reuse it
    assign op_eff          = state == IDLE ? io.io_in_op : op_reg;
    assign io.io_out_valid = valid_q;
    assign io.io_out_y     = y_q;
    assign io.io_out_zero  = y_q == '0;

    always_comb begin
        b = io.io_in_a[WIDTH-1:0];
        for (int k = 1; k < NUM_IN; k++) b = base(op_eff, b, io.io_in_a[k*WIDTH +: WIDTH]);
        acc_n = state == IDLE ? b : base(op_reg, acc, b);
        y_n = op_eff == 2'b11 ? ~acc_n : acc_n;
        state_n = fire_last ? IDLE : fire ? ACCUM : state;
    end

    always_ff @(posedge clock or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_n;

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            acc     <= '0;
            op_reg  <= 2'b00;
            y_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            if (fire && !io.io_in_last) begin
                acc    <= acc_n;
                op_reg <= op_eff;
            end
            if (fire_last) begin
                y_q     <= y_n;
                valid_q <= 1'b1;
            end else if (io.io_out_ready) valid_q <= 1'b0;
        end

`ifdef LOGIC_REDUCE_BEATS_EN
    logic [7:0] cnt, cnt_n, beats_q;
    assign cnt_n           = state == IDLE ? 8'd1 : cnt == 8'hFF ? cnt : cnt + 8'd1;
    assign io.io_out_beats = beats_q;

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            cnt     <= 8'd0;
            beats_q <= 8'd0;
        end else begin
            if (fire) cnt <= cnt_n;
            if (fire_last) beats_q <= cnt_n;
        end
`endif
endmodule

// File: tb/tb_logic_reduce_pipe.sv
// tb_logic_reduce_pipe: directed scoreboard bench for logic_reduce_pipe (WIDTH=8, NUM_IN=2)
module tb_logic_reduce_pipe;
    logic clock, reset;
    int   total = 0, passed = 0;

    typedef struct {
        logic [7:0] y;
        logic       z;
        logic [7:0] n;
    } exp_t;
    exp_t q[$];

    logic_reduce_pipe_if #(.WIDTH(8), .NUM_IN(2)) io ();
    logic_reduce_pipe #(.WIDTH(8), .NUM_IN(2)) dut (.clock(clock), .reset(reset), .io(io));

    initial clock = 0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic expect_out(input logic [7:0] y, input logic [7:0] n);
        exp_t e;
        e.y = y;
        e.z = y == 8'h00;
        e.n = n;
        q.push_back(e);
    endtask

    task automatic beat(input logic [1:0] op, input logic [7:0] a0, input logic [7:0] a1, input logic last);
        int n = 0;
        io.io_in_valid = 1;
        io.io_in_op    = op;
        io.io_in_a     = {a1, a0};
        io.io_in_last  = last;
        @(negedge clock);
        while (!io.io_in_ready && n < 1000) begin
            n++;
            @(negedge clock);
        end
        if (n == 1000) chk("in_ready_timeout", 0, 1);
        @(posedge clock);
        #1;
        io.io_in_valid = 0;
    endtask

    always @(negedge clock) begin : monitor
        exp_t e;
        if (!reset && io.io_out_valid && io.io_out_ready) begin
            if (q.size() == 0) chk("unexpected_output", 1, 0);
            else begin
                e = q.pop_front();
                chk("out_y", io.io_out_y, e.y);
                chk("out_zero", io.io_out_zero, e.z);
`ifdef LOGIC_REDUCE_BEATS_EN
                chk("out_beats", io.io_out_beats, e.n);
`endif
            end
        end
    end

    initial begin
        int n;
        reset           = 1;
        io.io_in_valid  = 0;
        io.io_in_op     = 0;
        io.io_in_a      = 0;
        io.io_in_last   = 0;
        io.io_out_ready = 1;
        repeat (2) @(negedge clock);
        chk("rst_valid", io.io_out_valid, 0);
        chk("rst_y", io.io_out_y, 0);
        chk("rst_zero", io.io_out_zero, 1);
        chk("rst_in_ready", io.io_in_ready, 1);
`ifdef LOGIC_REDUCE_BEATS_EN
        chk("rst_beats", io.io_out_beats, 0);
`endif
        @(posedge clock);
        #1 reset = 0;

        expect_out(8'h30, 1);
        beat(2'b00, 8'hF0, 8'h3C, 1);
        chk("latency_valid", io.io_out_valid, 1);
        chk("latency_y", io.io_out_y, 8'h30);
        @(posedge clock);
        #1;

        beat(2'b11, 8'hFF, 8'h0F, 0);
        repeat (3) @(posedge clock);
        #1;
        beat(2'b00, 8'hFF, 8'hFF, 0);
        expect_out(8'hF0, 3);
        beat(2'b01, 8'h0F, 8'hFF, 1);

        beat(2'b10, 8'hAA, 8'h55, 0);
        expect_out(8'h00, 2);
        beat(2'b00, 8'hFF, 8'h00, 1);
        @(posedge clock);
        #1;

        io.io_out_ready = 0;
        expect_out(8'h33, 1);
        beat(2'b01, 8'h11, 8'h22, 1);
        expect_out(8'h0E, 1);
        fork
            beat(2'b10, 8'h0F, 8'h01, 1);
        join_none
        repeat (3) begin
            @(negedge clock);
            chk("bp_in_ready", io.io_in_ready, 0);
            chk("bp_valid", io.io_out_valid, 1);
            chk("bp_y_held", io.io_out_y, 8'h33);
        end
        @(posedge clock);
        #1 io.io_out_ready = 1;
        @(negedge clock);
        chk("b2b_first", io.io_out_valid, 1);
        @(negedge clock);
        chk("b2b_second", io.io_out_valid, 1);
        chk("b2b_second_y", io.io_out_y, 8'h0E);
        wait fork;
        @(posedge clock);
        #1;

        beat(2'b01, 8'h01, 8'h00, 0);
        beat(2'b01, 8'h02, 8'h00, 0);
        #3 reset = 1;
        #1;
        chk("midrst_valid", io.io_out_valid, 0);
        chk("midrst_y", io.io_out_y, 0);
        chk("midrst_zero", io.io_out_zero, 1);
        @(posedge clock);
        #1 reset = 0;
        repeat (3) begin
            @(negedge clock);
            chk("postrst_no_output", io.io_out_valid, 0);
        end
        @(posedge clock);
        #1;
        expect_out(8'h03, 1);
        beat(2'b01, 8'h01, 8'h02, 1);

        for (int i = 1; i < 300; i++) beat(2'b00, 8'hFF, 8'hFF, 0);
        expect_out(8'h5A, 8'hFF);
        beat(2'b00, 8'h5A, 8'hFF, 1);

        n = 0;
        while (q.size() != 0 && n < 100) begin
            n++;
            @(posedge clock);
        end
        chk("drain_pending", q.size(), 0);
        repeat (2) @(posedge clock);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
